// File: rtl/tmds_channel_decoder.sv
// One TMDS receive lane: finds symbol alignment by bit-slipping until control
// tokens repeat at one offset, then decodes each aligned symbol to data or control.
module tmds_channel_decoder #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] rawWord,
  output logic [7:0] dataOut,
  output logic [1:0] ctrlOut,
  output logic       dataEnable,
  output logic       locked,
  output logic [3:0] bitSlipOffset
);

  localparam int IDLE_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int RUN_W    = $clog2(LOCK_COUNT + 1);
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

  localparam logic [RUN_W-1:0]  RUN_LIMIT    = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0]  RUN_ONE      = RUN_W'(1);
  localparam logic [RUN_W-1:0]  RUN_ZERO     = RUN_W'(0);
  localparam logic [RUN_W-1:0]  RUN_FULL     = {RUN_W{1'b1}};
  localparam logic [IDLE_W-1:0] SEARCH_LIMIT = IDLE_W'(SEARCH_TIMEOUT);
  localparam logic [IDLE_W-1:0] LOSS_LIMIT   = IDLE_W'(LOSS_TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_ONE     = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_ZERO    = IDLE_W'(0);
  localparam logic [IDLE_W-1:0] IDLE_FULL    = {IDLE_W{1'b1}};

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Returns {hit, C1, C0} for the four control tokens.
  function automatic logic [2:0] token_match(input logic [9:0] q);
    logic [2:0] res;
    case (q)
      10'h354: res = 3'b100;
      10'h0AB: res = 3'b101;
      10'h154: res = 3'b110;
      10'h2AB: res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] d_inv;
    logic [7:0] d;
    d_inv = q[9] ? ~q[7:0] : q[7:0];
    d[0]  = d_inv[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (d_inv[i] ^ d_inv[i-1]) : ~(d_inv[i] ^ d_inv[i-1]);
    end
    return d;
  endfunction

  logic [9:0]        r_prev_word;
  logic [9:0]        r_aligned;
  logic [1:0]        r_state;
  logic [RUN_W-1:0]  r_run;
  logic [IDLE_W-1:0] r_idle;
  logic [3:0]        r_offset;
  logic [7:0]        r_data;
  logic [1:0]        r_ctrl;
  logic              r_en;
  logic              r_locked;

  logic [19:0]       w_window;
  logic [19:0]       w_shifted;
  logic [9:0]        w_aligned;
  logic [2:0]        w_token;
  logic              w_hit;
  logic [RUN_W-1:0]  w_run_inc;
  logic [IDLE_W-1:0] w_idle_inc;
  logic [1:0]        w_state_nxt;
  logic [RUN_W-1:0]  w_run_nxt;
  logic [IDLE_W-1:0] w_idle_nxt;
  logic [3:0]        w_offset_nxt;
  logic              w_lock_nxt;
  logic [7:0]        w_data_nxt;
  logic [1:0]        w_ctrl_nxt;
  logic              w_en_nxt;

  assign w_window   = {rawWord, r_prev_word};
  assign w_shifted  = w_window >> r_offset;
  assign w_aligned  = w_shifted[9:0];
  assign w_token    = token_match(r_aligned);
  assign w_hit      = w_token[2];
  assign w_run_inc  = (r_run == RUN_FULL) ? r_run : r_run + RUN_ONE;
  assign w_idle_inc = (r_idle == IDLE_FULL) ? r_idle : r_idle + IDLE_ONE;

  // Alignment search / verify / lock-tracking decisions on the stage-1 symbol.
  always_comb begin
    w_state_nxt  = r_state;
    w_run_nxt    = r_run;
    w_idle_nxt   = r_idle;
    w_offset_nxt = r_offset;
    case (r_state)
      ST_SEARCH: begin
        if (w_hit) begin
          w_state_nxt = (RUN_ONE >= RUN_LIMIT) ? ST_LOCKED : ST_VERIFY;
          w_run_nxt   = RUN_ONE;
          w_idle_nxt  = IDLE_ZERO;
        end else if (w_idle_inc >= SEARCH_LIMIT) begin
          w_offset_nxt = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
          w_idle_nxt   = IDLE_ZERO;
        end else begin
          w_idle_nxt = w_idle_inc;
        end
      end
      ST_VERIFY: begin
        if (w_hit) begin
          w_run_nxt   = w_run_inc;
          w_state_nxt = (w_run_inc >= RUN_LIMIT) ? ST_LOCKED : ST_VERIFY;
        end else begin
          w_state_nxt = ST_SEARCH;
          w_run_nxt   = RUN_ZERO;
          w_idle_nxt  = IDLE_ZERO;
        end
      end
      ST_LOCKED: begin
        if (w_hit) begin
          w_idle_nxt = IDLE_ZERO;
        end else if (w_idle_inc >= LOSS_LIMIT) begin
          w_state_nxt = ST_SEARCH;
          w_run_nxt   = RUN_ZERO;
          w_idle_nxt  = IDLE_ZERO;
        end else begin
          w_idle_nxt = w_idle_inc;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
        w_run_nxt   = RUN_ZERO;
        w_idle_nxt  = IDLE_ZERO;
      end
    endcase
  end

  // Output selection uses the next lock state so lock and its first symbol coincide.
  always_comb begin
    w_lock_nxt = (w_state_nxt == ST_LOCKED);
    w_data_nxt = 8'h00;
    w_ctrl_nxt = 2'b00;
    w_en_nxt   = 1'b0;
    if (!w_lock_nxt) begin
      w_en_nxt = 1'b0;
    end else if (w_hit) begin
      w_ctrl_nxt = w_token[1:0];
    end else begin
      w_en_nxt   = 1'b1;
      w_data_nxt = tmds_decode(r_aligned);
      w_ctrl_nxt = r_ctrl;
    end
  end

  // Window capture, stage-1 alignment, control state and stage-2 outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev_word <= 10'd0;
      r_aligned   <= 10'd0;
      r_state     <= ST_SEARCH;
      r_run       <= RUN_ZERO;
      r_idle      <= IDLE_ZERO;
      r_offset    <= 4'd0;
      r_data      <= 8'h00;
      r_ctrl      <= 2'b00;
      r_en        <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_prev_word <= rawWord;
      r_aligned   <= w_aligned;
      r_state     <= w_state_nxt;
      r_run       <= w_run_nxt;
      r_idle      <= w_idle_nxt;
      r_offset    <= w_offset_nxt;
      r_data      <= w_data_nxt;
      r_ctrl      <= w_ctrl_nxt;
      r_en        <= w_en_nxt;
      r_locked    <= w_lock_nxt;
    end
  end

  assign dataOut       = r_data;
  assign ctrlOut       = r_ctrl;
  assign dataEnable    = r_en;
  assign locked        = r_locked;
  assign bitSlipOffset = r_offset;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: stimulus pushes hand-computed
// expectations into a due-cycle-ordered scoreboard that a monitor drains.
module tb_tmds_channel_decoder;

  logic       clock;
  logic       reset;
  logic [9:0] rawWord;
  logic [7:0] dataOut;
  logic [1:0] ctrlOut;
  logic       dataEnable;
  logic       locked;
  logic [3:0] bitSlipOffset;

  tmds_channel_decoder #(
    .LOCK_COUNT    (8),
    .SEARCH_TIMEOUT(16),
    .LOSS_TIMEOUT  (64)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rawWord      (rawWord),
    .dataOut      (dataOut),
    .ctrlOut      (ctrlOut),
    .dataEnable   (dataEnable),
    .locked       (locked),
    .bitSlipOffset(bitSlipOffset)
  );

  typedef struct {
    int         due;
    logic       en;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       lk;
    logic [3:0] off;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare every expectation that falls due on this cycle.
  always @(negedge clock) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.due != cyc) begin
        $display("FAIL %s: missed due cycle %0d (now %0d)", e.name, e.due, cyc);
      end else if ({dataEnable, dataOut, ctrlOut, locked, bitSlipOffset} !==
                   {e.en, e.data, e.ctrl, e.lk, e.off}) begin
        $display("FAIL %s @%0d: got en=%0b data=%02h ctrl=%02b lock=%0b off=%0d, want en=%0b data=%02h ctrl=%02b lock=%0b off=%0d",
                 e.name, cyc, dataEnable, dataOut, ctrlOut, locked, bitSlipOffset,
                 e.en, e.data, e.ctrl, e.lk, e.off);
      end else begin
        n_pass++;
      end
    end
  end

  task automatic push_exp(input int lat, input string nm, input logic en, input logic [7:0] d,
                          input logic [1:0] c, input logic lk, input logic [3:0] off);
    exp_t e;
    int   pos;
    e.due = cyc + lat; e.en = en; e.data = d; e.ctrl = c; e.lk = lk; e.off = off; e.name = nm;
    pos = sb.size();
    while (pos > 0 && sb[pos-1].due > e.due) pos--;
    sb.insert(pos, e);
  endtask

  task automatic drive(input logic rst, input logic [9:0] w);
    @(negedge clock);
    reset   = rst;
    rawWord = w;
  endtask

  // Word whose decoded output is due two edges after it is sampled.
  task automatic feed(input logic [9:0] w, input string nm, input logic en, input logic [7:0] d,
                      input logic [1:0] c, input logic lk);
    drive(1'b0, w);
    push_exp(3, nm, en, d, c, lk, 4'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
  endtask

  task automatic do_reset(input logic [9:0] w);
    drain();
    drive(1'b1, w);
    push_exp(1, "reset", 1'b0, 8'h00, 2'b00, 1'b0, 4'd0);
    drive(1'b1, 10'h000);
  endtask

  // Stream rotated by three bits; offset steps every 16 words, lock on word 57.
  task automatic search_to_3(input string nm);
    logic [3:0] off_e;
    for (int k = 1; k <= 60; k++) begin
      drive(1'b0, 10'h2A6);
      off_e = (k < 16) ? 4'd0 : (k < 32) ? 4'd1 : (k < 48) ? 4'd2 : 4'd3;
      push_exp(1, nm, 1'b0, 8'h00, 2'b00, (k >= 57), off_e);
    end
  endtask

  initial begin
    logic [3:0] off_w;
    reset   = 1'b1;
    rawWord = 10'h000;

    do_reset(10'h000);

    for (int i = 1; i <= 8; i++) feed(10'h354, "lock_tok", 1'b0, 8'h00, 2'b00, (i == 8));
    feed(10'h2AB, "tok_11", 1'b0, 8'h00, 2'b11, 1'b1);
    feed(10'h154, "tok_10", 1'b0, 8'h00, 2'b10, 1'b1);
    feed(10'h100, "data_00", 1'b1, 8'h00, 2'b10, 1'b1);
    feed(10'h2FF, "data_FE", 1'b1, 8'hFE, 2'b10, 1'b1);
    feed(10'h354, "tok_00", 1'b0, 8'h00, 2'b00, 1'b1);

    for (int i = 1; i <= 64; i++) begin
      if (i < 64) feed(10'h100, "loss_hold", 1'b1, 8'h00, 2'b00, 1'b1);
      else        feed(10'h100, "loss_drop", 1'b0, 8'h00, 2'b00, 1'b0);
    end

    for (int i = 1; i <= 5; i++) feed(10'h354, "short_run", 1'b0, 8'h00, 2'b00, 1'b0);
    feed(10'h100, "run_break", 1'b0, 8'h00, 2'b00, 1'b0);
    for (int i = 1; i <= 8; i++)
      feed(10'h0AB, "fresh_run", 1'b0, 8'h00, (i == 8) ? 2'b01 : 2'b00, (i == 8));

    // Offset walks 0..9 over 160 idle words and wraps to 0, then locks there.
    do_reset(10'h000);
    for (int k = 1; k <= 170; k++) begin
      drive(1'b0, (k <= 160) ? 10'h000 : 10'h354);
      off_w = (k < 160) ? 4'(k / 16) : 4'd0;
      push_exp(1, "wrap", 1'b0, 8'h00, 2'b00, (k >= 170), off_w);
    end

    do_reset(10'h000);
    search_to_3("search3");

    drain();
    drive(1'b0, 10'h2A6);
    push_exp(1, "pre_reset", 1'b0, 8'h00, 2'b00, 1'b1, 4'd3);
    drive(1'b1, 10'h2A6);
    push_exp(1, "reset_locked", 1'b0, 8'h00, 2'b00, 1'b0, 4'd0);
    search_to_3("research3");

    drain();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      $display("FAIL %s: expectation never compared (due %0d)", e.name, e.due);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
